// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply sequencer.
// The pipeline side uses modport master, the sequencer uses modport slave.
interface mul_seq_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_rs1_val;
    logic [XLEN-1:0]  in_rs2_val;
    logic [TAG_W-1:0] in_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;
    logic             busy;

    modport master (
        output in_valid, in_op, in_rs1_val, in_rs2_val, in_rd, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, busy
    );

    modport slave (
        input  in_valid, in_op, in_rs1_val, in_rs2_val, in_rd, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add sequencer for MUL/MULH/MULHSU/MULHU on unsigned magnitudes.
// Optional macro MUL_EARLY_OUT_EN finishes as soon as the remaining multiplier is zero.
module mul_seq_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    w_mcand_nxt;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    w_acc_nxt;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  w_mplier_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_neg;
    logic             w_neg_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [XLEN-1:0]  r_out_result;
    logic [XLEN-1:0]  w_result_nxt;
    logic [TAG_W-1:0] r_out_rd;
    logic [TAG_W-1:0] w_rd_nxt;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_in_ready;

    logic             w_sign1;
    logic             w_sign2;
    logic [XLEN-1:0]  w_mag1;
    logic [XLEN-1:0]  w_mag2;
    logic [PW-1:0]    w_acc_sum;
    logic [PW-1:0]    w_prod;
    logic [XLEN-1:0]  w_sel;
    logic             w_early;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL needs just the low half.
    assign w_sign1 = bus.in_rs1_val[XLEN-1] && ((bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU));
    assign w_sign2 = bus.in_rs2_val[XLEN-1] && (bus.in_op == OP_MULH);
    assign w_mag1  = w_sign1 ? XLEN'(-bus.in_rs1_val) : bus.in_rs1_val;
    assign w_mag2  = w_sign2 ? XLEN'(-bus.in_rs2_val) : bus.in_rs2_val;

    // Sum including this cycle's partial product; equals r_acc once the multiplier is exhausted.
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : PW'(0));
    assign w_prod    = r_neg ? PW'(-w_acc_sum) : w_acc_sum;
    assign w_sel     = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

`ifdef MUL_EARLY_OUT_EN
    assign w_early = (r_mplier == XLEN'(0));
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
            r_neg        <= 1'b0;
            r_op         <= '0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_mcand      <= w_mcand_nxt;
            r_acc        <= w_acc_nxt;
            r_mplier     <= w_mplier_nxt;
            r_cnt        <= w_cnt_nxt;
            r_neg        <= w_neg_nxt;
            r_op         <= w_op_nxt;
            r_out_result <= w_result_nxt;
            r_out_rd     <= w_rd_nxt;
            r_out_valid  <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_in_ready   <= (w_state_nxt == S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_acc_nxt    = r_acc;
        w_mplier_nxt = r_mplier;
        w_cnt_nxt    = r_cnt;
        w_neg_nxt    = r_neg;
        w_op_nxt     = r_op;
        w_result_nxt = r_out_result;
        w_rd_nxt     = r_out_rd;

        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    w_state_nxt  = S_CALC;
                    w_mcand_nxt  = {{XLEN{1'b0}}, w_mag1};
                    w_mplier_nxt = w_mag2;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_neg_nxt    = w_sign1 ^ w_sign2;
                    w_op_nxt     = bus.in_op;
                    w_rd_nxt     = bus.in_rd;
                end
            end
            S_CALC: begin
                if (w_early) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_sel;
                end else begin
                    w_acc_nxt    = w_acc_sum;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = w_sel;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over everything except reset; a pending result is dropped.
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_rd     = r_out_rd;
    assign bus.busy       = r_busy;
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Iterative radix-2 sequencer for the M-extension multiply ops (MUL, MULH, MULHSU, MULHU) emitted by the decoder.
- Sits in EX beside the ALU and accepts one operation per valid/ready handshake.
- Runs a 32-step shift-add, applies sign correction and returns the selected 32-bit half.
- While it holds an operation it drives busy, which the pipeline uses to stall. Flush aborts the operation in flight.

Parameters:
XLEN, 32, operand/result width; iteration counter is $clog2(XLEN) bits
TAG_W, 5, width of destination-register tag carried through

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept (high only in IDLE)
in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (= funct3[1:0])
in_rs1_val  in  XLEN  multiplicand
in_rs2_val  in  XLEN  multiplier
in_rd  in  TAG_W  destination tag
flush  in  1  abort operation in flight
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  XLEN  selected product half
out_rd  out  TAG_W  tag of the result
busy  out  1  state != IDLE

Behaviour:
- Interface: single clock clk; rst synchronous, active-high.
- Reset: state = IDLE; out_valid = 0, busy = 0, in_ready = 1; out_result = 0, out_rd = 0; counter and accumulator = 0.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE, accept on in_valid && in_ready && !flush. At the accept edge, capture:
  - in_op and in_rd.
  - Magnitudes |rs1| and |rs2|. rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only; MUL is treated as unsigned.
  - neg = sign1_eff ^ sign2_eff.
  - acc = 0, cnt = 0.
- Magnitude of 0x80000000 is 2^31, which fits unsigned XLEN; no overflow.
- CALC, each cycle:
  - If the multiplier LSB is 1, acc += multiplicand (2*XLEN-bit add).
  - Shift the multiplicand left 1 and the multiplier right 1; cnt++.
  - When cnt == XLEN-1, go to DONE.
- Entry to DONE registers the 2*XLEN product as neg ? -acc : acc.
  - out_result = low half for MUL, high half otherwise.
  - out_valid = 1.
- DONE:
  - out_result and out_rd stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE next cycle with out_valid = 0.
  - in_ready stays low in DONE, so there is no same-cycle accept.
- Latency: the accept edge is cycle 0; out_valid first goes high in cycle XLEN+1 (33). Throughput is one operation per 34 cycles with out_ready held high.
- flush, any state:
  - Next state IDLE; out_valid = 0; the result is discarded and never presented.
  - flush in IDLE with in_valid: the operation is not accepted.
  - flush in DONE together with out_ready: the handshake is void and the consumer ignores it.
- Priority: rst > flush > normal operation.
- rst mid-operation behaves like flush and also clears out_result and out_rd.
- in_* inputs are ignored outside IDLE.

Optional Feature:
MUL_EARLY_OUT_EN
- Defined:
  - In CALC, if the remaining (shifted) multiplier is 0 at the start of a cycle, go directly to DONE without further adds.
  - Multiplier 0: out_valid in cycle 2. Multiplier 1: out_valid in cycle 3.
  - Worst case stays 33.
  - Results are identical to the non-early path.
- Undefined: fixed 33-cycle latency, no zero-detect logic.

Test Plan:
1. MUL, rs1=7, rs2=6, out_ready=1 -> out_valid first high in cycle 33, out_result=0x0000002A, out_rd = captured tag; in_ready=1 the cycle after the handshake.
2. MULH, 0x80000000 * 0x80000000 -> 0x40000000. MULH, 0xFFFFFFFF(-1) * 0x00000002 -> 0xFFFFFFFF. MUL on the same operands -> 0xFFFFFFFE.
3. MULHSU, 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF_00000001). MULHU, same operands -> 0xFFFFFFFE.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result, out_rd and out_valid stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle, a new op is accepted and its result is correct.
5. Flush in CALC at cycle 10 -> state IDLE, busy=0, in_ready=1 next cycle, no out_valid ever for that op. Flush asserted with in_valid in IDLE -> not accepted. rst at cycle 20 -> all outputs at reset values next cycle.
6. MUL_EARLY_OUT_EN, MULHU with rs2=0 -> out_valid in cycle 2, result 0. rs2=1, rs1=0xDEADBEEF, MUL -> out_valid in cycle 3, result 0xDEADBEEF. Macro off, same stimulus -> cycle 33, same results.
